// File: rtl/display_scan_ctrl_if.sv
// Load/start/stop controls from the top-level FSM and the decoder/digit-enable outputs.
interface display_scan_ctrl_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_data;
  logic [4:0] len;
  logic       start;
  logic       stop;
  logic       busy;
  logic [4:0] code;
  logic [3:0] ssd_ctl;

  modport master (
    output wr_en, wr_addr, wr_data, len, start, stop,
    input  busy, code, ssd_ctl
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, start, stop,
    output busy, code, ssd_ctl
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexes a 16-letter message buffer onto one shared letter decoder,
// showing 1-4 letters statically and scrolling longer messages with wrap-around.
module display_scan_ctrl #(
  parameter int SCAN_DIV   = 50000,
  parameter int SCROLL_DIV = 25000000
) (
  input logic                clk,
  input logic                rst,
  display_scan_ctrl_if.slave bus
);

  localparam int SCAN_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int SCROLL_W = (SCROLL_DIV > 2) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [4:0] BLANK = 5'd15;

  typedef enum logic [1:0] {IDLE, SHOW, SCROLL} state_t;

  state_t              r_state, w_stateNext;
  logic [1:0]          r_digit, w_digitNext;
  logic [3:0]          r_offset, w_offsetNext;
  logic [4:0]          r_lenR, w_lenNext;
  logic [SCAN_W-1:0]   r_scanCnt, w_scanNext;
  logic [SCROLL_W-1:0] r_scrollCnt, w_scrollNext;
  logic [4:0]          r_buf [16];
  logic [4:0]          r_code, w_codeNext;
  logic [3:0]          r_ssdCtl;
  logic                r_busy;
  logic                w_scanTc, w_scrollTc, w_start;
  logic [4:0]          w_lenClamp, w_idx;

  assign w_scanTc   = (r_scanCnt == SCAN_W'(SCAN_DIV - 1));
  assign w_scrollTc = (r_scrollCnt == SCROLL_W'(SCROLL_DIV - 1));
  assign w_lenClamp = (bus.len > 5'd16) ? 5'd16 : bus.len;
  // stop has priority, and a zero length never starts anything
  assign w_start    = bus.start && !bus.stop && (bus.len != 5'd0);

  // Outputs are registered from next-cycle values so code always matches ssd_ctl.
  always_comb begin
    w_stateNext  = r_state;
    w_digitNext  = w_scanTc ? r_digit + 2'd1 : r_digit;
    w_scanNext   = w_scanTc ? '0 : r_scanCnt + SCAN_W'(1);
    w_offsetNext = r_offset;
    w_lenNext    = r_lenR;
    w_scrollNext = r_scrollCnt;
    w_idx        = 5'd0;
    w_codeNext   = BLANK;

    if (bus.stop && (r_state != IDLE)) begin
      w_stateNext = IDLE;
    end else if (w_start) begin
      w_stateNext  = (w_lenClamp <= 5'd4) ? SHOW : SCROLL;
      w_lenNext    = w_lenClamp;
      w_offsetNext = 4'd0;
      w_scrollNext = '0;
      w_digitNext  = 2'd0;
      w_scanNext   = '0;
    end else if (r_state == SCROLL) begin
      if (w_scrollTc) begin
        w_scrollNext = '0;
        w_offsetNext = ({1'b0, r_offset} == (r_lenR - 5'd1)) ? 4'd0 : r_offset + 4'd1;
      end else begin
        w_scrollNext = r_scrollCnt + SCROLL_W'(1);
      end
    end

    // offset+digit never exceeds 2*len_r-1 in SCROLL, so one subtract wraps it
    w_idx = {1'b0, w_offsetNext} + {3'b000, w_digitNext};
    if (w_idx >= w_lenNext) w_idx = w_idx - w_lenNext;

    case (w_stateNext)
      SHOW:    w_codeNext = ({3'b000, w_digitNext} < w_lenNext) ? r_buf[{2'b00, w_digitNext}] : BLANK;
      SCROLL:  w_codeNext = r_buf[w_idx[3:0]];
      default: w_codeNext = BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_digit     <= 2'd0;
      r_offset    <= 4'd0;
      r_lenR      <= 5'd1;
      r_scanCnt   <= '0;
      r_scrollCnt <= '0;
      r_code      <= BLANK;
      r_ssdCtl    <= 4'b1110;
      r_busy      <= 1'b0;
      for (int i = 0; i < 16; i++) r_buf[i] <= BLANK;
    end else begin
      r_state     <= w_stateNext;
      r_digit     <= w_digitNext;
      r_offset    <= w_offsetNext;
      r_lenR      <= w_lenNext;
      r_scanCnt   <= w_scanNext;
      r_scrollCnt <= w_scrollNext;
      r_code      <= w_codeNext;
      r_ssdCtl    <= ~(4'b0001 << w_digitNext);
      r_busy      <= (w_stateNext != IDLE);
      if (bus.wr_en) r_buf[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.code    = r_code;
  assign bus.ssd_ctl = r_ssdCtl;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: stimulus queues the expected digit
// presentations, a negedge monitor compares each time the enabled digit changes.
module tb_display_scan_ctrl;

  typedef struct {
    logic       busy;
    logic [4:0] code;
    logic [3:0] ssd;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         total = 0;
  int         bad = 0;
  exp_t       expQ[$];
  logic [3:0] prevSsd = 4'bxxxx;

  int showTab[4]      = '{0, 1, 2, 15};
  int msgTab[6]       = '{5, 2, 7, 7, 12, 15};
  int scrollTab[7][4] = '{'{5, 2, 7, 7}, '{2, 7, 7, 12}, '{7, 7, 12, 15}, '{7, 12, 15, 5},
                          '{12, 15, 5, 2}, '{15, 5, 2, 7}, '{5, 2, 7, 7}};
  int liveTab[16]     = '{16, 17, 13, 19, 16, 17, 13, 19, 17, 13, 19, 20, 17, 13, 19, 20};

  display_scan_ctrl_if bus();

  display_scan_ctrl #(.SCAN_DIV(2), .SCROLL_DIV(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] digitMask(input int d);
    case (d % 4)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic pushExp(input logic b, input int c, input int d, input string n);
    exp_t e;
    e.busy = b;
    e.code = 5'(c);
    e.ssd  = digitMask(d);
    e.name = n;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if (bus.busy !== e.busy || bus.code !== e.code || bus.ssd_ctl !== e.ssd) begin
      bad++;
      $display("[TB] FAIL %s: got busy=%b code=%0d ssd_ctl=%b, expected busy=%b code=%0d ssd_ctl=%b",
               e.name, bus.busy, bus.code, bus.ssd_ctl, e.busy, e.code, e.ssd);
    end
  endtask

  // A presentation is any change of the enabled digit.
  always @(negedge clk) begin
    if (bus.ssd_ctl !== prevSsd && expQ.size() > 0) checkOutput(expQ.pop_front());
    prevSsd = bus.ssd_ctl;
  end

  task automatic applyStimulus(input int addr, input int data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(addr);
    bus.wr_data = 5'(data);
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
  endtask

  // Returns at the negedge where digit 3 has just been enabled.
  task automatic syncDigit3();
    int n = 0;
    @(negedge clk);
    while (bus.ssd_ctl === 4'b0111 && n < 40) begin @(negedge clk); n++; end
    while (bus.ssd_ctl !== 4'b0111 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      total++;
      bad++;
      $display("[TB] FAIL sync: ssd_ctl=%b after %0d cycles, expected 0111", bus.ssd_ctl, n);
    end
  endtask

  task automatic issueCtl(input logic s, input logic p, input int l);
    syncDigit3();
    bus.start = s;
    bus.stop  = p;
    bus.len   = 5'(l);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic waitDrain(input string n, input int budget);
    int c = 0;
    while (expQ.size() > 0 && c < budget) begin @(posedge clk); c++; end
    if (expQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s drain: %0d presentations outstanding, expected 0", n, expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = 4'd0;
    bus.wr_data = 5'd0;
    bus.len     = 5'd0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int j = 1; j <= 10; j++) pushExp(1'b0, 15, j, "reset");
    waitDrain("reset", 40);

    for (int i = 0; i < 3; i++) applyStimulus(i, i);
    issueCtl(1'b1, 1'b0, 3);
    for (int j = 0; j < 32; j++) pushExp(1'b1, showTab[j % 4], j, "show");
    waitDrain("show", 100);

    for (int i = 0; i < 6; i++) applyStimulus(i, msgTab[i]);
    issueCtl(1'b1, 1'b0, 6);
    for (int j = 0; j < 56; j++) pushExp(1'b1, scrollTab[j / 8][j % 4], j, "scroll");
    waitDrain("scroll", 150);

    // stop and start together: digit keeps running, display blanks
    issueCtl(1'b1, 1'b1, 3);
    for (int j = 0; j < 8; j++) pushExp(1'b0, 15, j, "startstop");
    waitDrain("startstop", 40);

    issueCtl(1'b1, 1'b0, 0);
    for (int j = 0; j < 8; j++) pushExp(1'b0, 15, j, "len0");
    waitDrain("len0", 40);

    for (int i = 0; i < 16; i++) applyStimulus(i, 16 + i);
    issueCtl(1'b1, 1'b0, 20);
    for (int j = 0; j < 136; j++) pushExp(1'b1, 16 + ((((j / 8) % 16) + (j % 4)) % 16), j, "len20");
    waitDrain("len20", 300);

    issueCtl(1'b1, 1'b0, 6);
    for (int j = 0; j < 16; j++) pushExp(1'b1, liveTab[j], j, "live");
    applyStimulus(2, 13);
    waitDrain("live", 60);

    syncDigit3();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int j = 0; j < 5; j++) pushExp(1'b0, 15, j, "rstmid");
    waitDrain("rstmid", 30);

    issueCtl(1'b1, 1'b0, 3);
    for (int j = 0; j < 8; j++) pushExp(1'b1, 15, j, "bufclear");
    waitDrain("bufclear", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
